// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory read port, instr handshake to
// decode, and the control inputs that steer the next PC.
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic [31:0]     instr;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            PCsrc;
    logic            JALR;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] alu_result;

    modport master (
        output imem_req, imem_addr, instr, instr_valid, pc, pc_plus4,
        input  imem_gnt, imem_rvalid, imem_rdata, instr_ready,
               PCsrc, JALR, imm_ext, alu_result
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid, pc, pc_plus4,
        output imem_gnt, imem_rvalid, imem_rdata, instr_ready,
               PCsrc, JALR, imm_ext, alu_result
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch with PC ownership: one outstanding imem read, holds instr
// until decode accepts. Define FETCH_MISALIGN_TRAP_EN to trap misaligned targets.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic          misalign_err
`endif
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_HALT
    } state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] tgt_raw;
    logic [XLEN-1:0] target;
    logic            accept;
    logic            misalign;

    assign accept = (state == S_HOLD) && bus.instr_ready;

    always_comb begin
        tgt_raw = pc_q + XLEN'(4);
        if (bus.PCsrc) begin
            if (bus.JALR) tgt_raw = bus.alu_result & ~XLEN'(1);
            else          tgt_raw = pc_q + bus.imm_ext;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target   = tgt_raw;
    assign misalign = (tgt_raw[1:0] != 2'b00);
`else
    // Without the trap, low bits are dropped so fetch always stays word-aligned.
    assign target   = tgt_raw & ~XLEN'(3);
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        bus.imem_req    = 1'b0;
        bus.instr_valid = 1'b0;
        case (state)
            S_IDLE:  state_nxt = S_FETCH;
            S_FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_gnt) state_nxt = S_WAIT;
            end
            S_WAIT:  if (bus.imem_rvalid) state_nxt = S_HOLD;
            S_HOLD: begin
                bus.instr_valid = 1'b1;
                if (bus.instr_ready) state_nxt = misalign ? S_HALT : S_FETCH;
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Responses outside S_WAIT (e.g. stale ones from before a reset) are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP;
        end else begin
            if (state == S_WAIT && bus.imem_rvalid) instr_q <= bus.imem_rdata;
            if (accept) pc_q <= target;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      misalign_err <= 1'b0;
        else if (accept && misalign)  misalign_err <= 1'b1;
    end
`endif

    assign bus.imem_addr = pc_q;
    assign bus.pc        = pc_q;
    assign bus.pc_plus4  = pc_q + XLEN'(4);
    assign bus.instr     = instr_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; inputs driven and outputs
// sampled on the falling clock edge.
module tb_fetch_unit;
    logic clk;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    fetch_unit_if #(.XLEN(32)) bus ();
`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_err;
    fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus), .misalign_err(misalign_err));
`else
    fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0; bus.instr_ready = 0;
        bus.PCsrc = 0; bus.JALR = 0; bus.imm_ext = 0; bus.alu_result = 0;
    endtask

    // Leaves the DUT released from reset at a falling edge, in S_IDLE.
    task automatic do_reset();
        @(negedge clk); rst = 1; clear_inputs();
        @(negedge clk); rst = 0;
    endtask

    // Waits (bounded) for a request, grants it, returns data one cycle later.
    task automatic fetch_to_hold(input logic [31:0] data);
        int n = 0;
        while (bus.imem_req !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        total++; if (bus.imem_req !== 1'b1) $display("FAIL f2h_req_timeout: got %b want 1", bus.imem_req); else passed++;
        bus.imem_gnt = 1;
        @(negedge clk); bus.imem_gnt = 0; bus.imem_rvalid = 1; bus.imem_rdata = data;
        @(negedge clk); bus.imem_rvalid = 0; bus.imem_rdata = 0;
    endtask

    // Accept with the given steering; afterwards controls carry junk that must be ignored.
    task automatic accept(input logic ps, input logic jr, input logic [31:0] imm, input logic [31:0] alu);
        bus.instr_ready = 1; bus.PCsrc = ps; bus.JALR = jr; bus.imm_ext = imm; bus.alu_result = alu;
        @(negedge clk);
        bus.instr_ready = 0; bus.PCsrc = 1; bus.JALR = 1; bus.imm_ext = 32'h40; bus.alu_result = 32'h1235;
    endtask

    task automatic test_reset();
        @(negedge clk); rst = 1; clear_inputs(); #1;
        total++; if (bus.imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", bus.imem_req); else passed++;
        total++; if (bus.instr_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.instr_valid); else passed++;
        total++; if (bus.instr !== 32'h13) $display("FAIL rst_instr: got %h want 00000013", bus.instr); else passed++;
        total++; if (bus.pc !== 32'h0) $display("FAIL rst_pc: got %h want 00000000", bus.pc); else passed++;
        total++; if (bus.pc_plus4 !== 32'h4) $display("FAIL rst_pc4: got %h want 00000004", bus.pc_plus4); else passed++;
`ifdef FETCH_MISALIGN_TRAP_EN
        total++; if (misalign_err !== 1'b0) $display("FAIL rst_misalign: got %b want 0", misalign_err); else passed++;
`endif
        @(negedge clk); rst = 0;
    endtask

    task automatic test_basic();
        @(negedge clk);
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) $display("FAIL basic_req: got req=%b addr=%h want 1/0", bus.imem_req, bus.imem_addr); else passed++;
        bus.imem_gnt = 1;
        @(negedge clk); bus.imem_gnt = 0; bus.imem_rvalid = 1; bus.imem_rdata = 32'h00500093;
        total++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) $display("FAIL basic_wait: got req=%b vld=%b want 0/0", bus.imem_req, bus.instr_valid); else passed++;
        @(negedge clk); bus.imem_rvalid = 0;
        total++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h00500093) $display("FAIL basic_instr: got vld=%b instr=%h want 1/00500093", bus.instr_valid, bus.instr); else passed++;
        accept(0, 0, 0, 0);
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4 || bus.instr_valid !== 1'b0) $display("FAIL basic_next: got req=%b addr=%h vld=%b want 1/4/0", bus.imem_req, bus.imem_addr, bus.instr_valid); else passed++;
    endtask

    task automatic test_gnt_stall();
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.instr_valid !== 1'b0) $display("FAIL stall_%0d: got req=%b addr=%h vld=%b want 1/0/0", i, bus.imem_req, bus.imem_addr, bus.instr_valid); else passed++;
            @(negedge clk);
        end
        bus.imem_gnt = 1;
        @(negedge clk); bus.imem_gnt = 0;
        total++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) $display("FAIL stall_wait0: got vld=%b req=%b want 0/0", bus.instr_valid, bus.imem_req); else passed++;
        @(negedge clk);
        total++; if (bus.instr_valid !== 1'b0) $display("FAIL stall_wait1: got vld=%b want 0", bus.instr_valid); else passed++;
        bus.imem_rvalid = 1; bus.imem_rdata = 32'h00200113;
        @(negedge clk); bus.imem_rvalid = 0;
        total++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h00200113) $display("FAIL stall_instr: got vld=%b instr=%h want 1/00200113", bus.instr_valid, bus.instr); else passed++;
    endtask

    task automatic test_hold_branch();
        do_reset();
        fetch_to_hold(32'h00000033);
        accept(1, 0, 32'h10, 0);
        total++; if (bus.imem_addr !== 32'h10 || bus.imem_req !== 1'b1) $display("FAIL br_addr: got req=%b addr=%h want 1/10", bus.imem_req, bus.imem_addr); else passed++;
        fetch_to_hold(32'h00A00113);
        bus.PCsrc = 1; bus.imm_ext = 32'h100;
        for (int i = 0; i < 5; i++) begin
            total++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h00A00113 || bus.pc !== 32'h10) $display("FAIL hold_%0d: got vld=%b instr=%h pc=%h want 1/00a00113/10", i, bus.instr_valid, bus.instr, bus.pc); else passed++;
            @(negedge clk);
        end
        accept(1, 0, 32'hFFFF_FFF8, 0);
        total++; if (bus.imem_addr !== 32'h8 || bus.imem_req !== 1'b1) $display("FAIL br_neg: got req=%b addr=%h want 1/8", bus.imem_req, bus.imem_addr); else passed++;
    endtask

    task automatic test_jalr();
        fetch_to_hold(32'h0180006F);
        accept(1, 0, 32'h18, 0);
        total++; if (bus.imem_addr !== 32'h20) $display("FAIL jalr_pre: got addr=%h want 20", bus.imem_addr); else passed++;
        fetch_to_hold(32'h000080E7);
        total++; if (bus.pc_plus4 !== 32'h24 || bus.pc !== 32'h20) $display("FAIL jalr_pc4: got pc=%h pc4=%h want 20/24", bus.pc, bus.pc_plus4); else passed++;
        accept(1, 1, 32'h7770, 32'h105);
        total++; if (bus.imem_addr !== 32'h104) $display("FAIL jalr_tgt: got addr=%h want 104", bus.imem_addr); else passed++;
    endtask

    task automatic test_ready_not_valid();
        bus.instr_ready = 1; bus.PCsrc = 1; bus.JALR = 0; bus.imm_ext = 32'h100; bus.imem_gnt = 1;
        @(negedge clk); bus.imem_gnt = 0;
        total++; if (bus.pc !== 32'h104 || bus.instr_valid !== 1'b0) $display("FAIL rdy_idle_pc: got pc=%h vld=%b want 104/0", bus.pc, bus.instr_valid); else passed++;
        bus.instr_ready = 0; bus.imem_rvalid = 1; bus.imem_rdata = 32'h00308193;
        @(negedge clk); bus.imem_rvalid = 0;
        total++; if (bus.instr_valid !== 1'b1 || bus.pc !== 32'h104 || bus.instr !== 32'h00308193) $display("FAIL rdy_idle_hold: got vld=%b pc=%h instr=%h want 1/104/00308193", bus.instr_valid, bus.pc, bus.instr); else passed++;
        accept(0, 0, 0, 0);
        total++; if (bus.imem_addr !== 32'h108) $display("FAIL rdy_idle_next: got addr=%h want 108", bus.imem_addr); else passed++;
    endtask

    task automatic test_reset_abort();
        rst = 1; #1;
        total++; if (bus.imem_req !== 1'b0) $display("FAIL abort_fetch_req: got %b want 0", bus.imem_req); else passed++;
        clear_inputs();
        @(negedge clk); rst = 0;
        @(negedge clk); bus.imem_gnt = 1;
        @(negedge clk); bus.imem_gnt = 0;
        rst = 1; #1;
        total++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.pc !== 32'h0) $display("FAIL abort_wait: got req=%b vld=%b pc=%h want 0/0/0", bus.imem_req, bus.instr_valid, bus.pc); else passed++;
        @(negedge clk); rst = 0; bus.imem_rvalid = 1; bus.imem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        total++; if (bus.instr_valid !== 1'b0 || bus.instr !== 32'h13 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) $display("FAIL stale_idle: got vld=%b instr=%h req=%b addr=%h want 0/00000013/1/0", bus.instr_valid, bus.instr, bus.imem_req, bus.imem_addr); else passed++;
        @(negedge clk); bus.imem_rvalid = 0; bus.imem_rdata = 0;
        total++; if (bus.instr_valid !== 1'b0 || bus.instr !== 32'h13) $display("FAIL stale_fetch: got vld=%b instr=%h want 0/00000013", bus.instr_valid, bus.instr); else passed++;
        fetch_to_hold(32'h00100073);
        total++; if (bus.instr !== 32'h00100073 || bus.pc !== 32'h0) $display("FAIL abort_recover: got instr=%h pc=%h want 00100073/0", bus.instr, bus.pc); else passed++;
    endtask

    task automatic test_wrap();
        accept(1, 0, 32'hFFFF_FFFC, 0);
        total++; if (bus.imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr: got %h want fffffffc", bus.imem_addr); else passed++;
        fetch_to_hold(32'h00000013);
        total++; if (bus.pc_plus4 !== 32'h0) $display("FAIL wrap_pc4: got %h want 00000000", bus.pc_plus4); else passed++;
        accept(0, 0, 0, 0);
        total++; if (bus.imem_addr !== 32'h0 || bus.imem_req !== 1'b1) $display("FAIL wrap_next: got req=%b addr=%h want 1/0", bus.imem_req, bus.imem_addr); else passed++;
    endtask

    task automatic test_misalign();
        fetch_to_hold(32'h0020006F);
        accept(1, 0, 32'h2, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
        bus.imem_gnt = 1;
        for (int i = 0; i < 3; i++) begin
            total++; if (misalign_err !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.pc !== 32'h2) $display("FAIL halt_%0d: got err=%b req=%b vld=%b pc=%h want 1/0/0/2", i, misalign_err, bus.imem_req, bus.instr_valid, bus.pc); else passed++;
            @(negedge clk);
        end
        bus.imem_gnt = 0;
`else
        total++; if (bus.imem_addr !== 32'h0 || bus.imem_req !== 1'b1) $display("FAIL misalign_fold: got req=%b addr=%h want 1/0", bus.imem_req, bus.imem_addr); else passed++;
`endif
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_basic();
        test_gnt_stall();
        test_hold_branch();
        test_jalr();
        test_ready_not_valid();
        test_reset_abort();
        test_wrap();
        test_misalign();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Supplies instructions to the control unit and datapath. Also owns the program counter.
- Issues one instruction-memory read at a time, holds the returned instruction stable until the decode stage accepts it, then advances the PC.
- The next PC is either PC+4 or a branch/jump target selected by the control-unit outputs PCsrc and JALR.
- Sits between the instruction memory and cu/datapath. It is the producer side of the instr bus that cu decodes.

Parameters:
- XLEN, 32, data/address width
- RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- imem_req  out  1  read request valid
- imem_addr  out  XLEN  word-aligned read address (= pc)
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  read data
- instr  out  32  held instruction to cu/datapath
- instr_valid  out  1  instr is valid
- instr_ready  in  1  decode consumes instr this cycle
- pc  out  XLEN  address of current instr
- pc_plus4  out  XLEN  pc+4, for JAL/JALR writeback
- PCsrc  in  1  take target (branch taken or jump); sampled only on accept
- JALR  in  1  target from alu_result instead of pc+imm
- imm_ext  in  XLEN  sign-extended immediate
- alu_result  in  XLEN  rs1+imm from ALU, for JALR

Behaviour:
- Reset (asynchronous, active-high): state=S_IDLE, pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0, imem_req=0, misalign_err=0.
- States:
  - S_IDLE: imem_req=0. Next cycle goes to S_FETCH.
  - S_FETCH: imem_req=1, imem_addr=pc. If imem_gnt, go to S_WAIT; else stay. Request stays asserted with a stable address until granted.
  - S_WAIT: imem_req=0. On imem_rvalid, register imem_rdata into instr, set instr_valid=1, go to S_HOLD.
  - S_HOLD: instr_valid=1; instr and pc held stable. On instr_ready (accept), go to S_FETCH with the next pc, and clear instr_valid in the same edge.
- Next pc on accept:
  - PCsrc=0: pc+4.
  - PCsrc=1, JALR=0: pc+imm_ext.
  - PCsrc=1, JALR=1: {alu_result[XLEN-1:1],1'b0}.
- PCsrc, JALR, imm_ext and alu_result are ignored on all cycles other than an accept cycle.
- Response rules:
  - imem_rvalid in any state other than S_WAIT is discarded. This covers stale responses after reset.
  - Only one outstanding request.
  - imem_rvalid may arrive one or more cycles after grant, never in the grant cycle.
- Latency:
  - Minimum 3 cycles from accept to the next instr_valid: S_FETCH (grant), S_WAIT (rvalid), then instr_valid visible in S_HOLD.
  - Throughput at most one instruction per 3 cycles.
- pc_plus4 = pc+4, combinational. All adds wrap modulo 2^XLEN: pc=32'hFFFF_FFFC gives pc_plus4=32'h0000_0000.
- instr_ready while instr_valid=0 has no effect.
- Reset asserted mid-request aborts immediately; imem_req drops asynchronously.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port misalign_err (1 bit, reset 0).
  - An accept whose computed target has target[1:0]!=0 sets misalign_err (sticky until rst) and enters S_HALT.
  - S_HALT: imem_req=0, instr_valid=0, pc = faulting target. Exit only by reset.
- Not defined:
  - No port.
  - target[1:0] is forced to 2'b00 and fetch proceeds normally.

Test Plan:
- Reset release, imem grants immediately, rvalid 1 cycle later with 32'h00500093, instr_ready=1 -> imem_addr=0, instr=32'h00500093 valid 2 cycles after first req, next imem_addr=4.
- Hold imem_gnt=0 for 4 cycles -> imem_req stays 1 and imem_addr stays 0; no instr_valid until grant+rvalid.
- instr valid at pc=0x10, instr_ready=0 for 5 cycles, then 1 with PCsrc=1, JALR=0, imm_ext=-8 -> instr stable throughout, next imem_addr=0x08.
- Accept at pc=0x20 with PCsrc=1, JALR=1, alu_result=0x105 -> next imem_addr=0x104, pc_plus4 was 0x24 during hold.
- rst pulsed while in S_WAIT, then stale imem_rvalid with 32'hDEADBEEF arrives in S_IDLE -> ignored, instr_valid=0, first fetch is RESET_PC.
- With FETCH_MISALIGN_TRAP_EN: accept with PCsrc=1, imm_ext=2 at pc=0 -> misalign_err=1, imem_req stays 0, pc=0x2. Without it: next imem_addr=0x0.
